btb_assoc: RTL and testbench

BTB_ASSOC -- requirements
Module: btb_assoc

---
 rtl/general_defines.sv | 22 ++
 rtl/btb_age_lru.sv | 58 +++++
 rtl/btb_assoc.sv | 157 +++++++++++++++
 tb/tb_btb_assoc.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/general_defines.sv
`default_nettype none
// ============================================================================
// Package : general_defines
// Purpose : Shared widths and default sizing for the branch target buffer.
//           INSTR_MEM_IDX_W is the width of an instruction-memory index (PC).
// Revision: 1.0 - initial release
// ============================================================================
package general_defines;

  localparam int INSTR_MEM_IDX_W  = 8;
  localparam int DEFAULT_NUM_SETS = 16;
  localparam int DEFAULT_NUM_WAYS = 2;
  localparam int DEFAULT_CTR_W    = 2;

  // Index width that never collapses to zero bits (a 1-way set still needs
  // a legal 1-bit way index).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btb_age_lru.sv
`default_nettype none
// ============================================================================
// Module  : btb_age_lru
// Purpose : Age-based LRU state for one BTB set. Ages are a permutation of
//           0..NUM_WAYS-1; a touched way becomes age 0 and every way that was
//           younger than it ages by one. o_oldest names the way at age
//           NUM_WAYS-1. With NUM_WAYS=1 no age state exists.
// Ports   : clk, rst_n       - clock, async active-low reset
//           i_touch          - update/allocate hits this set this cycle
//           i_touch_way      - way being touched
//           o_oldest         - way holding the maximum age
// Revision: 1.0 - initial release
// ============================================================================
module btb_age_lru #(
  parameter int NUM_WAYS  = 2,
  parameter int WAY_IDX_W = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_touch,
  input  logic [WAY_IDX_W-1:0] i_touch_way,
  output logic [WAY_IDX_W-1:0] o_oldest
);

  generate
    if (NUM_WAYS == 1) begin : g_no_age
      logic w_unused;
      assign w_unused = ^{clk, rst_n, i_touch, i_touch_way};
      assign o_oldest = '0;
    end else begin : g_age
      logic [WAY_IDX_W-1:0] r_age [NUM_WAYS];
      logic [WAY_IDX_W-1:0] w_touch_age;

      assign w_touch_age = r_age[i_touch_way];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int w = 0; w < NUM_WAYS; w++) r_age[w] <= WAY_IDX_W'(w);
        end else if (i_touch) begin
          for (int w = 0; w < NUM_WAYS; w++) begin
            if (WAY_IDX_W'(w) == i_touch_way)
              r_age[w] <= '0;
            else if (r_age[w] < w_touch_age)
              r_age[w] <= r_age[w] + 1'b1;
          end
        end
      end

      always_comb begin
        o_oldest = '0;
        for (int w = 0; w < NUM_WAYS; w++)
          if (r_age[w] == WAY_IDX_W'(NUM_WAYS - 1)) o_oldest = WAY_IDX_W'(w);
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/btb_assoc.sv
`default_nettype none
// ============================================================================
// Module  : btb_assoc
// Purpose : Set-associative branch target buffer with per-entry saturating
//           direction counters and age-based LRU replacement. Lookup is
//           purely combinational on the pre-edge state.
// Ports   : clk, rst_n                     - clock, async active-low reset
//           fetch_pc                       - lookup PC
//           btb_hit/btb_taken/btb_target   - lookup result (zero on miss)
//           update_valid/update_pc/
//           update_target/update_taken     - resolved branch
//           flush                          - invalidate all entries
// Revision: 1.0 - initial release
// ============================================================================
module btb_assoc
  import general_defines::*;
#(
  parameter int NUM_SETS = DEFAULT_NUM_SETS,
  parameter int NUM_WAYS = DEFAULT_NUM_WAYS,
  parameter int CTR_W    = DEFAULT_CTR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [INSTR_MEM_IDX_W-1:0] fetch_pc,
  output logic                       btb_hit,
  output logic                       btb_taken,
  output logic [INSTR_MEM_IDX_W-1:0] btb_target,
  input  logic                       update_valid,
  input  logic [INSTR_MEM_IDX_W-1:0] update_pc,
  input  logic [INSTR_MEM_IDX_W-1:0] update_target,
  input  logic                       update_taken,
  input  logic                       flush
);

  localparam int SET_IDX_W = $clog2(NUM_SETS);
  localparam int WAY_IDX_W = idx_w(NUM_WAYS);
  localparam logic [CTR_W-1:0] c_CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] c_CTR_INIT = CTR_W'(1) << (CTR_W - 1);

  logic                       r_valid  [NUM_SETS][NUM_WAYS];
  logic [INSTR_MEM_IDX_W-1:0] r_tag    [NUM_SETS][NUM_WAYS];
  logic [INSTR_MEM_IDX_W-1:0] r_target [NUM_SETS][NUM_WAYS];
  logic [CTR_W-1:0]           r_ctr    [NUM_SETS][NUM_WAYS];

  logic [SET_IDX_W-1:0] w_fset;
  logic [SET_IDX_W-1:0] w_uset;
  logic                 w_uhit;
  logic [WAY_IDX_W-1:0] w_uhit_way;
  logic                 w_free;
  logic [WAY_IDX_W-1:0] w_free_way;
  logic [WAY_IDX_W-1:0] w_victim;
  logic [WAY_IDX_W-1:0] w_wr_way;
  logic                 w_wr_en;
  logic [CTR_W-1:0]     w_old_ctr;
  logic [CTR_W-1:0]     w_ctr_next;
  logic [NUM_SETS-1:0]  w_touch;
  logic [WAY_IDX_W-1:0] w_oldest [NUM_SETS];

  assign w_fset = fetch_pc[SET_IDX_W-1:0];
  assign w_uset = update_pc[SET_IDX_W-1:0];

  // Lookup: full-PC tag compare within the indexed set.
  always_comb begin
    btb_hit    = 1'b0;
    btb_taken  = 1'b0;
    btb_target = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[w_fset][w] && (r_tag[w_fset][w] == fetch_pc)) begin
        btb_hit    = 1'b1;
        btb_taken  = r_ctr[w_fset][w][CTR_W-1];
        btb_target = r_target[w_fset][w];
      end
    end
  end

  // Update-side tag match and lowest-index free way in the update set.
  always_comb begin
    w_uhit     = 1'b0;
    w_uhit_way = '0;
    w_free     = 1'b0;
    w_free_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[w_uset][w] && (r_tag[w_uset][w] == update_pc)) begin
        w_uhit     = 1'b1;
        w_uhit_way = WAY_IDX_W'(w);
      end
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_uset][w]) begin
        w_free     = 1'b1;
        w_free_way = WAY_IDX_W'(w);
      end
    end
  end

  assign w_victim = w_free ? w_free_way : w_oldest[w_uset];
  assign w_wr_way = w_uhit ? w_uhit_way : w_victim;
  // Not-taken misses never allocate, so they cause no write at all.
  assign w_wr_en  = update_valid && (w_uhit || update_taken);

  assign w_old_ctr = r_ctr[w_uset][w_uhit_way];
  always_comb begin
    w_ctr_next = w_old_ctr;
    if (update_taken) begin
      if (w_old_ctr != c_CTR_MAX) w_ctr_next = w_old_ctr + 1'b1;
    end else begin
      if (w_old_ctr != '0) w_ctr_next = w_old_ctr - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          r_valid[s][w]  <= 1'b0;
          r_tag[s][w]    <= '0;
          r_target[s][w] <= '0;
          r_ctr[s][w]    <= '0;
        end
      end
    end else if (flush) begin
      // Flush only drops valid bits; counters and ages keep their values.
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          r_valid[s][w] <= 1'b0;
    end else if (w_wr_en) begin
      r_valid[w_uset][w_wr_way] <= 1'b1;
      r_tag[w_uset][w_wr_way]   <= update_pc;
      if (w_uhit) begin
        r_ctr[w_uset][w_wr_way] <= w_ctr_next;
        if (update_taken) r_target[w_uset][w_wr_way] <= update_target;
      end else begin
        r_ctr[w_uset][w_wr_way]    <= c_CTR_INIT;
        r_target[w_uset][w_wr_way] <= update_target;
      end
    end
  end

  generate
    for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
      assign w_touch[s] = w_wr_en && !flush && (w_uset == SET_IDX_W'(s));

      btb_age_lru #(
        .NUM_WAYS  (NUM_WAYS),
        .WAY_IDX_W (WAY_IDX_W)
      ) u_lru (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_touch     (w_touch[s]),
        .i_touch_way (w_wr_way),
        .o_oldest    (w_oldest[s])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_btb_assoc.sv
`default_nettype none
// ============================================================================
// Module  : tb_btb_assoc
// Purpose : Self-checking bench for btb_assoc (16 sets, 2 ways, 2-bit ctr).
// Revision: 1.0 - initial release
// ============================================================================
module tb_btb_assoc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] fetch_pc;
  logic       btb_hit;
  logic       btb_taken;
  logic [7:0] btb_target;
  logic       update_valid;
  logic [7:0] update_pc;
  logic [7:0] update_target;
  logic       update_taken;
  logic       flush;

  always #5 clk = ~clk;

  btb_assoc #(.NUM_SETS(16), .NUM_WAYS(2), .CTR_W(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_pc      (fetch_pc),
    .btb_hit       (btb_hit),
    .btb_taken     (btb_taken),
    .btb_target    (btb_target),
    .update_valid  (update_valid),
    .update_pc     (update_pc),
    .update_target (update_target),
    .update_taken  (update_taken),
    .flush         (flush)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model: LRU kept as a recency list ----------
  bit         m_valid [16][2];
  logic [7:0] m_tag   [16][2];
  logic [7:0] m_tgt   [16][2];
  int         m_ctr   [16][2];
  int         m_order [16][$];   // front = most recent; position = age

  task automatic model_reset();
    for (int s = 0; s < 16; s++) begin
      m_order[s].delete();
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 0; m_tag[s][w] = 0; m_tgt[s][w] = 0; m_ctr[s][w] = 0;
        m_order[s].push_back(w);
      end
    end
  endtask

  task automatic model_touch(input int s, input int w);
    for (int i = 0; i < m_order[s].size(); i++)
      if (m_order[s][i] == w) begin m_order[s].delete(i); break; end
    m_order[s].push_front(w);
  endtask

  task automatic model_update(input bit uv, input bit fl, input bit ut,
                              input logic [7:0] upc, input logic [7:0] utgt);
    int s, hw, v;
    if (fl) begin
      for (int a = 0; a < 16; a++) for (int b = 0; b < 2; b++) m_valid[a][b] = 0;
      return;
    end
    if (!uv) return;
    s = upc % 16;
    hw = -1;
    for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_tag[s][w] == upc) hw = w;
    if (hw >= 0) begin
      m_ctr[s][hw] = ut ? ((m_ctr[s][hw] < 3) ? m_ctr[s][hw] + 1 : 3)
                        : ((m_ctr[s][hw] > 0) ? m_ctr[s][hw] - 1 : 0);
      if (ut) m_tgt[s][hw] = utgt;
      model_touch(s, hw);
    end else if (ut) begin
      v = -1;
      for (int w = 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
      if (v < 0) v = m_order[s][m_order[s].size() - 1];
      m_valid[s][v] = 1; m_tag[s][v] = upc; m_tgt[s][v] = utgt; m_ctr[s][v] = 2;
      model_touch(s, v);
    end
  endtask

  task automatic model_lookup(input logic [7:0] pc, output bit h, output bit t,
                              output logic [7:0] tg);
    int s;
    s = pc % 16;
    h = 0; t = 0; tg = 0;
    for (int w = 0; w < 2; w++)
      if (m_valid[s][w] && m_tag[s][w] == pc) begin
        h = 1; t = (m_ctr[s][w] >= 2); tg = m_tgt[s][w];
      end
  endtask

  // ---------------- cycle helpers -----------------------------------------
  task automatic drive(input bit uv, input bit fl, input bit ut,
                       input logic [7:0] upc, input logic [7:0] utgt, input logic [7:0] fpc);
    update_valid = uv; flush = fl; update_taken = ut;
    update_pc = upc; update_target = utgt; fetch_pc = fpc;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update(update_valid, flush, update_taken, update_pc, update_target);
    #1;
  endtask

  typedef struct {
    bit uv; bit fl; bit ut;
    logic [7:0] upc; logic [7:0] utgt; logic [7:0] fpc;
    bit eh; bit et; logic [7:0] etgt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit uv, bit fl, bit ut, logic [7:0] upc, logic [7:0] utgt,
                              logic [7:0] fpc, bit eh, bit et, logic [7:0] etgt);
    vec_t v;
    v.uv = uv; v.fl = fl; v.ut = ut; v.upc = upc; v.utgt = utgt; v.fpc = fpc;
    v.eh = eh; v.et = et; v.etgt = etgt;
    return v;
  endfunction

  initial begin
    bit mh, mt;
    logic [7:0] mtg;
    logic [7:0] rpc, rfpc;

    rst_n = 1'b0;
    update_valid = 0; flush = 0; update_taken = 0;
    update_pc = 0; update_target = 0; fetch_pc = 8'h05;
    model_reset();
    @(posedge clk); #1;
    chk("in_reset_hit", btb_hit, 0);
    chk("in_reset_tgt", btb_target, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // expected values are the pre-edge view of each cycle
    vecs.push_back(mk(1,0,1, 8'h05,8'h40, 8'h05, 0,0,8'h00)); // reset state, no bypass
    vecs.push_back(mk(0,0,0, 8'h00,8'h00, 8'h05, 1,1,8'h40));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00, 8'h15, 0,0,8'h00));
    vecs.push_back(mk(1,0,0, 8'h05,8'h77, 8'h05, 1,1,8'h40)); // ctr 2->1
    vecs.push_back(mk(1,0,0, 8'h05,8'h77, 8'h05, 1,0,8'h40)); // ctr 1->0
    vecs.push_back(mk(1,0,0, 8'h05,8'h77, 8'h05, 1,0,8'h40)); // stays 0
    vecs.push_back(mk(0,0,0, 8'h00,8'h00, 8'h05, 1,0,8'h40));
    vecs.push_back(mk(1,0,1, 8'h05,8'h41, 8'h05, 1,0,8'h40)); // ctr 0->1, tgt 41
    vecs.push_back(mk(1,0,1, 8'h05,8'h41, 8'h05, 1,0,8'h41)); // ctr 1->2
    vecs.push_back(mk(0,0,0, 8'h00,8'h00, 8'h05, 1,1,8'h41));
    vecs.push_back(mk(1,0,1, 8'h15,8'h50, 8'h15, 0,0,8'h00)); // alloc way1
    vecs.push_back(mk(1,0,1, 8'h05,8'h41, 8'h15, 1,1,8'h50)); // touch 05
    vecs.push_back(mk(1,0,1, 8'h25,8'h60, 8'h05, 1,1,8'h41)); // evicts 15
    vecs.push_back(mk(0,0,0, 8'h00,8'h00, 8'h15, 0,0,8'h00));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00, 8'h25, 1,1,8'h60));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00, 8'h05, 1,1,8'h41));
    vecs.push_back(mk(1,1,1, 8'h35,8'h70, 8'h05, 1,1,8'h41)); // flush + update
    vecs.push_back(mk(0,0,0, 8'h00,8'h00, 8'h05, 0,0,8'h00));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00, 8'h25, 0,0,8'h00));
    vecs.push_back(mk(0,0,0, 8'h00,8'h00, 8'h35, 0,0,8'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].uv, vecs[i].fl, vecs[i].ut, vecs[i].upc, vecs[i].utgt, vecs[i].fpc);
      chk($sformatf("vec%0d_hit", i), btb_hit, vecs[i].eh);
      chk($sformatf("vec%0d_taken", i), btb_taken, vecs[i].et);
      chk($sformatf("vec%0d_tgt", i), btb_target, vecs[i].etgt);
      advance();
    end

    // randomized traffic over two conflicting sets against the model
    for (int c = 0; c < 3000; c++) begin
      rpc  = 8'(($urandom_range(0, 3) << 4) | ($urandom_range(0, 1) ? 5 : 6));
      rfpc = 8'(($urandom_range(0, 3) << 4) | ($urandom_range(0, 1) ? 5 : 6));
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
            $urandom_range(0, 9) < 6, rpc, 8'($urandom), rfpc);
      model_lookup(fetch_pc, mh, mt, mtg);
      chk($sformatf("rnd%0d_hit", c), btb_hit, mh);
      chk($sformatf("rnd%0d_taken", c), btb_taken, mt);
      chk($sformatf("rnd%0d_tgt", c), btb_target, mtg);
      advance();
    end

    // reset asserted in the middle of an update cycle
    drive(1, 0, 1, 8'h0B, 8'h22, 8'h0B);
    advance();
    drive(1, 0, 1, 8'h0A, 8'h33, 8'h0B);
    chk("pre_rst_hit", btb_hit, 1);
    chk("pre_rst_tgt", btb_target, 8'h22);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_hit", btb_hit, 0);
    chk("async_rst_taken", btb_taken, 0);
    chk("async_rst_tgt", btb_target, 0);
    @(posedge clk); #1;
    chk("held_rst_hit", btb_hit, 0);
    rst_n = 1'b1;
    model_reset();
    drive(0, 0, 0, 8'h00, 8'h00, 8'h0A);
    chk("rst_drop_upd_hit", btb_hit, 0);
    advance();
    drive(0, 0, 0, 8'h00, 8'h00, 8'h0B);
    chk("rst_clear_hit", btb_hit, 0);
    advance();

    // post-reset ages: alloc two, third evicts way with age 1
    drive(1, 0, 1, 8'h07, 8'h11, 8'h07); advance();
    drive(1, 0, 1, 8'h17, 8'h12, 8'h07); advance();
    drive(1, 0, 1, 8'h27, 8'h13, 8'h07); advance();
    drive(0, 0, 0, 8'h00, 8'h00, 8'h07);
    chk("lru_evict_07", btb_hit, 0);
    advance();
    drive(0, 0, 0, 8'h00, 8'h00, 8'h17);
    chk("lru_keep_17", btb_hit, 1);
    chk("lru_keep_17_tgt", btb_target, 8'h12);
    advance();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
